// File: rtl/fir_pkg.sv
// fir_pkg: register map, CTRL/STATUS bit positions, MAC FSM encoding and the accumulator width helper.
package fir_pkg;
  localparam logic [2:0] ADDR_CTRL      = 3'd0;
  localparam logic [2:0] ADDR_STATUS    = 3'd1;
  localparam logic [2:0] ADDR_COEF_IDX  = 3'd2;
  localparam logic [2:0] ADDR_COEF_DATA = 3'd3;
  localparam logic [2:0] ADDR_X_IN      = 3'd4;
  localparam logic [2:0] ADDR_Y_OUT     = 3'd5;
  localparam logic [2:0] ADDR_ID        = 3'd6;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_CLR    = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_SAT  = 2;
  localparam int ST_DROP = 3;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MAC = 2'd1, S_OUT = 2'd2} state_t;
  // Full-precision products plus enough guard bits to sum TAPS of them without overflow.
  function automatic int acc_width(input int dw, input int taps);
    return 2 * dw + $clog2(taps);
  endfunction
endpackage

// File: rtl/fir_mac_engine.sv
// fir_mac_engine: one-multiplier MAC walking TAPS taps, then shifts and saturates into a DATA_WIDTH result.
module fir_mac_engine import fir_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int TAPS = 16,
  parameter int SHIFT = 0,
  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, TAPS),
  localparam int IW = $clog2(TAPS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_start,
  input  logic signed [DATA_WIDTH-1:0] i_coef,
  input  logic signed [DATA_WIDTH-1:0] i_x,
  output logic [IW-1:0]                o_k,
  output logic [DATA_WIDTH-1:0]        o_y,
  output logic                         o_y_valid,
  output logic                         o_sat,
  output logic                         o_busy
);
  state_t r_state, w_next;
  logic [IW-1:0] r_k;
  logic signed [ACC_WIDTH-1:0] r_acc, w_sh;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic w_idle, w_mac, w_out, w_pos_ovf, w_neg_ovf;

  always_ff @(posedge clk) r_state <= reset ? S_IDLE : w_next;

  always_comb
    w_next = r_state == S_IDLE ? (i_start ? S_MAC : S_IDLE) :
             r_state == S_MAC  ? (r_k == IW'(TAPS - 1) ? S_OUT : S_MAC) : S_IDLE;

  always_comb begin
    w_idle = r_state == S_IDLE;
    w_mac  = r_state == S_MAC;
    w_out  = r_state == S_OUT;
    o_busy = !w_idle;
    o_k    = r_k;
  end

  assign w_prod = i_coef * i_x;
  assign w_sh = r_acc >>> SHIFT;
  // Result fits only when every bit above the DATA_WIDTH sign bit matches the accumulator sign.
  assign w_pos_ovf = !w_sh[ACC_WIDTH-1] && (|w_sh[ACC_WIDTH-2:DATA_WIDTH-1]);
  assign w_neg_ovf = w_sh[ACC_WIDTH-1] && !(&w_sh[ACC_WIDTH-2:DATA_WIDTH-1]);

  always_ff @(posedge clk)
    if (reset) begin
      r_k       <= '0;
      r_acc     <= '0;
      o_y       <= '0;
      o_y_valid <= 1'b0;
      o_sat     <= 1'b0;
    end else begin
      o_y_valid <= w_out;
      if (w_idle && i_start) begin
        r_k   <= '0;
        r_acc <= '0;
      end else if (w_mac) begin
        r_acc <= r_acc + ACC_WIDTH'(w_prod);
        r_k   <= r_k + IW'(1);
      end
      if (w_out) begin
        o_y   <= w_pos_ovf ? {1'b0, {(DATA_WIDTH-1){1'b1}}} :
                 w_neg_ovf ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : w_sh[DATA_WIDTH-1:0];
        o_sat <= w_pos_ovf | w_neg_ovf;
      end
    end
endmodule

// File: rtl/fir_mm_slave.sv
// fir_mm_slave: memory-mapped FIR slave; register file, coefficient bank and delay line around the MAC engine.
module fir_mm_slave import fir_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int TAPS = 16,
  parameter int SHIFT = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  write,
  input  logic                  read,
  input  logic [2:0]            addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  irq
);
  localparam int IW = $clog2(TAPS);
  logic [DATA_WIDTH-1:0] r_coef [TAPS];
  logic [DATA_WIDTH-1:0] r_x [TAPS];
  logic [DATA_WIDTH-1:0] r_y, w_y, w_rdata, w_ctrl, w_status, w_coef, w_x;
  logic [IW-1:0] r_idx, w_k;
  logic r_en, r_irq_en, r_busy, r_done, r_sat, r_drop;
  logic w_wr, w_rd, w_busy, w_push, w_start, w_coef_wr, w_clr, w_drop, w_w1c, w_y_rd, w_y_valid, w_sat;

  always_comb begin
    w_wr      = cs & write;
    w_rd      = cs & read;
    w_push    = w_wr && addr == ADDR_X_IN && r_en;
    w_start   = w_push && !w_busy;
    w_coef_wr = w_wr && addr == ADDR_COEF_DATA;
    w_clr     = w_wr && addr == ADDR_CTRL && write_data[CTRL_CLR];
    w_drop    = w_busy && (w_push || w_coef_wr || w_clr);
    w_w1c     = w_wr && addr == ADDR_STATUS;
    w_y_rd    = w_rd && addr == ADDR_Y_OUT;
    w_coef    = r_coef[w_k];
    w_x       = r_x[w_k];
  end

  fir_mac_engine #(.DATA_WIDTH(DATA_WIDTH), .TAPS(TAPS), .SHIFT(SHIFT)) u_mac (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_start),
    .i_coef    (w_coef),
    .i_x       (w_x),
    .o_k       (w_k),
    .o_y       (w_y),
    .o_y_valid (w_y_valid),
    .o_sat     (w_sat),
    .o_busy    (w_busy)
  );

  // Storage is frozen while the engine walks it; index writes stay legal at any time.
  always_ff @(posedge clk)
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        r_coef[i] <= '0;
        r_x[i]    <= '0;
      end
      r_idx <= '0;
    end else begin
      if (w_coef_wr && !w_busy) begin
        r_coef[r_idx] <= write_data;
        r_idx         <= r_idx == IW'(TAPS - 1) ? '0 : r_idx + IW'(1);
      end else if (w_wr && addr == ADDR_COEF_IDX) r_idx <= IW'(write_data % TAPS);
      if (w_start) begin
        r_x[0] <= write_data;
        for (int i = 1; i < TAPS; i++) r_x[i] <= r_x[i-1];
      end else if (w_clr && !w_busy) for (int i = 0; i < TAPS; i++) r_x[i] <= '0;
    end

  // Flag sets take priority over same-cycle W1C or Y_OUT read clears.
  always_ff @(posedge clk)
    if (reset) begin
      r_en      <= 1'b0;
      r_irq_en  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sat     <= 1'b0;
      r_drop    <= 1'b0;
      r_y       <= '0;
      read_data <= '0;
    end else begin
      if (w_wr && addr == ADDR_CTRL) begin
        r_en     <= write_data[CTRL_EN];
        r_irq_en <= write_data[CTRL_IRQ_EN];
      end
      r_busy <= w_busy;
      r_done <= w_y_valid | (r_done & !(w_w1c & write_data[ST_DONE]) & !w_y_rd);
      r_sat  <= (w_y_valid & w_sat) | (r_sat & !(w_w1c & write_data[ST_SAT]));
      r_drop <= w_drop | (r_drop & !(w_w1c & write_data[ST_DROP]));
      if (w_y_valid) r_y <= w_y;
      if (w_rd) read_data <= w_rdata;
    end

  always_comb begin
    w_ctrl = '0;
    w_ctrl[CTRL_EN] = r_en;
    w_ctrl[CTRL_IRQ_EN] = r_irq_en;
    w_status = '0;
    w_status[ST_BUSY] = r_busy;
    w_status[ST_DONE] = r_done;
    w_status[ST_SAT] = r_sat;
    w_status[ST_DROP] = r_drop;
    w_rdata = addr == ADDR_CTRL      ? w_ctrl :
              addr == ADDR_STATUS    ? w_status :
              addr == ADDR_COEF_IDX  ? DATA_WIDTH'(r_idx) :
              addr == ADDR_COEF_DATA ? r_coef[r_idx] :
              addr == ADDR_Y_OUT     ? r_y :
              addr == ADDR_ID        ? DATA_WIDTH'(TAPS) : '0;
  end

  assign irq = r_done & r_irq_en;
endmodule

// File: tb/tb_fir_mm_slave.sv
// tb_fir_mm_slave: randomized bus-level bench; results are compared against a dot-product model of the filter.
module tb_fir_mm_slave;
  localparam int DW = 32;
  localparam int TAPS = 16;
  localparam int SH = 0;

  logic clk = 1'b0;
  logic reset, cs, write, read, irq;
  logic [2:0] addr;
  logic [DW-1:0] write_data, read_data;
  int n_checks = 0;
  int n_errors = 0;
  logic signed [DW-1:0] mcoef [TAPS];
  logic signed [DW-1:0] mx [TAPS];

  fir_mm_slave #(.DATA_WIDTH(DW), .TAPS(TAPS), .SHIFT(SH)) dut (
    .clk        (clk),
    .reset      (reset),
    .cs         (cs),
    .write      (write),
    .read       (read),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = a; write_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [DW-1:0] d);
    @(negedge clk);
    cs = 1'b1; read = 1'b1; addr = a;
    @(negedge clk);
    cs = 1'b0; read = 1'b0;
    d = read_data;
  endtask

  function automatic void m_clear(input bit coefs);
    for (int k = 0; k < TAPS; k++) begin
      mx[k] = '0;
      if (coefs) mcoef[k] = '0;
    end
  endfunction

  function automatic void m_push(input logic [DW-1:0] v);
    for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = v;
  endfunction

  // y = sat((sum coef[k]*x[k]) >>> SHIFT), computed in wide exact arithmetic
  function automatic logic [DW-1:0] model_y(output logic s);
    logic signed [127:0] acc, hi, lo;
    acc = '0;
    for (int k = 0; k < TAPS; k++) acc += mcoef[k] * mx[k];
    acc = acc >>> SH;
    hi = 128'sh7FFFFFFF;
    lo = -128'sh80000000;
    s = acc > hi || acc < lo;
    return acc > hi ? 32'h7FFFFFFF : acc < lo ? 32'h80000000 : acc[DW-1:0];
  endfunction

  task automatic load_coefs(input int mode);
    logic signed [11:0] r12;
    bus_write(3'd2, '0);
    for (int k = 0; k < TAPS; k++) begin
      r12 = 12'($urandom);
      mcoef[k] = mode == 0 ? DW'(k + 1) : mode == 1 ? 32'h7FFFFFFF : DW'(r12);
      bus_write(3'd3, mcoef[k]);
    end
  endtask

  task automatic wait_done();
    logic [DW-1:0] s;
    int n;
    n = 0;
    do begin
      bus_read(3'd1, s);
      n++;
    end while (!s[1] && n < 100);
    check("done_wait", 64'(s[1]), 64'd1);
  endtask

  task automatic push_check(input logic [DW-1:0] v, input string tag, output logic [DW-1:0] y);
    logic [DW-1:0] st, exp;
    logic s;
    bus_write(3'd1, 32'hE);
    bus_write(3'd4, v);
    m_push(v);
    wait_done();
    bus_read(3'd5, y);
    exp = model_y(s);
    check({tag, "_y"}, 64'(y), 64'(exp));
    bus_read(3'd1, st);
    check({tag, "_status"}, 64'(st), 64'({s, 2'b00}));
  endtask

  initial begin
    logic [DW-1:0] d, y, v, exp;
    logic s;
    logic signed [11:0] r12;
    int first_irq, busy_cnt;
    cs = 1'b0; write = 1'b0; read = 1'b0; addr = '0; write_data = '0; reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_clear(1'b1);
    check("rst_irq", 64'(irq), 64'd0);
    bus_read(3'd1, d); check("rst_status", 64'(d), 64'd0);
    bus_read(3'd5, d); check("rst_y", 64'(d), 64'd0);
    bus_read(3'd6, d); check("rst_id", 64'(d), 64'd16);
    bus_read(3'd0, d); check("rst_ctrl", 64'(d), 64'd0);
    bus_read(3'd7, d); check("rsvd", 64'(d), 64'd0);

    load_coefs(0);
    bus_read(3'd2, d); check("idx_wrap", 64'(d), 64'd0);
    bus_write(3'd2, 32'd3);
    bus_read(3'd3, d); check("coef_rd", 64'(d), 64'd4);
    bus_read(3'd3, d); check("coef_rd_again", 64'(d), 64'd4);
    bus_write(3'd2, 32'd21);
    bus_read(3'd2, d); check("idx_mod", 64'(d), 64'd5);
    bus_write(3'd4, 32'd9);
    bus_read(3'd1, d); check("push_disabled", 64'(d), 64'd0);
    bus_write(3'd0, 32'd1);
    push_check(32'd1, "imp0", y);
    check("imp0_const", 64'(y), 64'd1);
    for (int i = 1; i < TAPS; i++) begin
      push_check(32'd0, $sformatf("imp%0d", i), y);
      check($sformatf("imp%0d_const", i), 64'(y), 64'(i + 1));
    end
    push_check(32'd0, "imp16", y);
    check("imp16_const", 64'(y), 64'd0);

    bus_write(3'd0, 32'd5);
    r12 = 12'($urandom);
    v = DW'(r12);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = 3'd4; write_data = v;
    m_push(v);
    @(negedge clk);
    write = 1'b0; read = 1'b1; addr = 3'd1;
    first_irq = -1;
    busy_cnt = 0;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      if (irq && first_irq < 0) first_irq = n;
      if (read_data[0]) busy_cnt++;
    end
    cs = 1'b0; read = 1'b0;
    check("lat_done_edge", 64'(first_irq), 64'd18);
    check("lat_busy_cycles", 64'(busy_cnt), 64'd17);
    bus_read(3'd5, y);
    exp = model_y(s);
    check("lat_y", 64'(y), 64'(exp));
    check("lat_irq_clear", 64'(irq), 64'd0);

    bus_write(3'd0, 32'd1);
    bus_write(3'd1, 32'hE);
    r12 = 12'($urandom);
    v = DW'(r12);
    bus_write(3'd4, v);
    m_push(v);
    bus_write(3'd4, 32'h123);
    bus_write(3'd3, 32'hDEAD);
    bus_write(3'd0, 32'd3);
    wait_done();
    bus_read(3'd1, d); check("drop_status", 64'(d), 64'hA);
    bus_read(3'd5, y);
    exp = model_y(s);
    check("drop_y", 64'(y), 64'(exp));
    bus_read(3'd2, d); check("drop_idx", 64'(d), 64'd5);
    bus_write(3'd1, 32'h8);
    bus_read(3'd1, d); check("drop_w1c", 64'(d), 64'd0);
    push_check(32'd0, "drop_hist", y);

    for (int r = 0; r < 6; r++) begin
      load_coefs(2);
      if (r % 2 == 1) begin
        bus_write(3'd0, 32'd3);
        m_clear(1'b0);
        bus_read(3'd0, d); check($sformatf("ctrl_rd%0d", r), 64'(d), 64'd1);
      end
      for (int p = 0; p < 3; p++) begin
        r12 = 12'($urandom);
        push_check(DW'(r12), $sformatf("rnd%0d_%0d", r, p), y);
      end
    end

    load_coefs(1);
    bus_write(3'd0, 32'd3);
    m_clear(1'b0);
    push_check(32'h7FFFFFFF, "sat_pos", y);
    check("sat_pos_const", 64'(y), 64'h7FFFFFFF);
    bus_write(3'd0, 32'd3);
    m_clear(1'b0);
    push_check(32'h80000000, "sat_neg", y);
    check("sat_neg_const", 64'(y), 64'h80000000);

    bus_write(3'd4, 32'd77);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_clear(1'b1);
    bus_read(3'd1, d); check("rst_mid_status", 64'(d), 64'd0);
    check("rst_mid_irq", 64'(irq), 64'd0);
    bus_read(3'd3, d); check("rst_mid_coef", 64'(d), 64'd0);
    load_coefs(0);
    bus_write(3'd0, 32'd1);
    push_check(32'd3, "reload", y);
    check("reload_const", 64'(y), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
